fp32_divider: RTL and testbench



---
 rtl/fp32_pkg.sv | 29 ++
 rtl/fp32_div_round.sv | 75 +++++++
 rtl/fp32_divider.sv | 178 +++++++++++++++++
 tb/tb_fp32_divider.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pkg
// Description : Shared FP32 constants, packed FP32 field type and the state
//               encoding of the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    localparam int         FP_EXP_BIAS = 127;
    localparam logic [7:0] FP_EXP_MAX  = 8'hFF;
    localparam int         FP_MANT_W   = 23;
    localparam int         FP_DIV_ITER = 27;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/fp32_div_round.sv
`default_nettype none
// ============================================================================
// Module      : fp32_div_round
// Description : Combinational normalise / round / pack stage for a 27-bit
//               quotient. FP_DIV_RNE_EN selects round-to-nearest-even;
//               without it the mantissa is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_div_round
    import fp32_pkg::*;
(
    input  logic [FP_DIV_ITER-1:0] i_q,
    input  logic                   i_rem_nz,
    input  logic signed [9:0]      i_exp,
    input  logic                   i_sign,
    output logic [31:0]            o_result,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    logic signed [9:0]    w_exp_norm;
    logic signed [9:0]    w_exp_rnd;
    logic [FP_MANT_W-1:0] w_mant_norm;
    logic [FP_MANT_W-1:0] w_mant_rnd;
    fp32_t                w_pack;

    // A quotient below 1.0 has its leading one one place lower
    assign w_exp_norm  = i_q[26] ? i_exp : i_exp - 10'sd1;
    assign w_mant_norm = i_q[26] ? i_q[25:3] : i_q[24:2];

`ifdef FP_DIV_RNE_EN
    logic               w_guard;
    logic               w_round;
    logic               w_sticky;
    logic               w_round_up;
    logic [FP_MANT_W:0] w_mant_sum;

    assign w_guard    = i_q[26] ? i_q[2] : i_q[1];
    assign w_round    = i_q[26] ? i_q[1] : i_q[0];
    assign w_sticky   = i_q[26] ? (i_q[0] | i_rem_nz) : i_rem_nz;
    assign w_round_up = w_guard & (w_round | w_sticky | w_mant_norm[0]);
    assign w_mant_sum = {1'b0, w_mant_norm} + {{FP_MANT_W{1'b0}}, w_round_up};
    // On carry-out the low bits are already all zero
    assign w_mant_rnd = w_mant_sum[FP_MANT_W-1:0];
    assign w_exp_rnd  = w_exp_norm + $signed({9'd0, w_mant_sum[FP_MANT_W]});
`else
    logic w_unused_trunc;

    assign w_unused_trunc = ^{i_q[1:0], i_rem_nz};
    assign w_mant_rnd     = w_mant_norm;
    assign w_exp_rnd      = w_exp_norm;
`endif

    // Saturate to infinity or flush to zero when the exponent leaves range
    always_comb begin
        o_overflow    = 1'b0;
        o_underflow   = 1'b0;
        w_pack.sign   = i_sign;
        w_pack.exp    = w_exp_rnd[7:0];
        w_pack.mant   = w_mant_rnd;
        if (w_exp_rnd >= 10'sd255) begin
            o_overflow  = 1'b1;
            w_pack.exp  = FP_EXP_MAX;
            w_pack.mant = '0;
        end else if (w_exp_rnd <= 10'sd0) begin
            o_underflow = 1'b1;
            w_pack.exp  = 8'd0;
            w_pack.mant = '0;
        end
    end

    assign o_result = w_pack;

endmodule
`default_nettype wire

// File: rtl/fp32_divider.sv
`default_nettype none
// ============================================================================
// Module      : fp32_divider
// Description : Sequential IEEE-754 single-precision divider with a 27-step
//               radix-2 restoring mantissa divider and valid/ready handshakes.
//               Build option FP_DIV_RNE_EN enables round-to-nearest-even,
//               otherwise results are truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_divider
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic        DivByZero
);

    div_state_t        r_state;
    div_state_t        w_state_nxt;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [23:0]       r_mb;
    logic [24:0]       r_rem;
    logic [26:0]       r_q;
    logic [4:0]        r_iter;
    logic [31:0]       r_result;
    logic              r_exception;
    logic              r_overflow;
    logic              r_underflow;
    logic              r_div_by_zero;

    fp32_t             w_a;
    fp32_t             w_b;
    logic              w_sign;
    logic              w_special;
    logic [31:0]       w_spec_result;
    logic              w_spec_exc;
    logic              w_spec_dbz;
    logic              w_ge;
    logic [24:0]       w_rem_sub;
    logic              w_last_iter;
    logic [31:0]       w_rnd_result;
    logic              w_rnd_overflow;
    logic              w_rnd_underflow;

    assign w_a         = a_operand;
    assign w_b         = b_operand;
    assign w_sign      = w_a.sign ^ w_b.sign;
    assign w_special   = (w_a.exp == 8'd0) || (w_b.exp == 8'd0) ||
                         (w_a.exp == FP_EXP_MAX) || (w_b.exp == FP_EXP_MAX);
    assign w_ge        = r_rem >= {1'b0, r_mb};
    assign w_rem_sub   = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
    assign w_last_iter = (r_iter == 5'(FP_DIV_ITER - 1));

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign Exception = r_exception;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;
    assign DivByZero = r_div_by_zero;

    // Resolve the special operand combinations directly from the inputs
    always_comb begin
        w_spec_result = '0;
        w_spec_exc    = 1'b0;
        w_spec_dbz    = 1'b0;
        if ((w_a.exp == FP_EXP_MAX) || (w_b.exp == FP_EXP_MAX)) begin
            w_spec_exc = 1'b1;
        end else if ((w_a.exp == 8'd0) && (w_b.exp == 8'd0)) begin
            w_spec_exc = 1'b1;
        end else if (w_b.exp == 8'd0) begin
            w_spec_dbz    = 1'b1;
            w_spec_result = {w_sign, FP_EXP_MAX, 23'd0};
        end else if (w_a.exp == 8'd0) begin
            w_spec_result = {w_sign, 31'd0};
        end
    end

    fp32_div_round u_round (
        .i_q        (r_q),
        .i_rem_nz   (r_rem != 25'd0),
        .i_exp      (r_exp),
        .i_sign     (r_sign),
        .o_result   (w_rnd_result),
        .o_overflow (w_rnd_overflow),
        .o_underflow(w_rnd_underflow)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid) w_state_nxt = w_special ? ST_DONE : ST_DIVIDE;
            ST_DIVIDE: if (w_last_iter) w_state_nxt = ST_ROUND;
            ST_ROUND:  w_state_nxt = ST_DONE;
            ST_DONE:   if (out_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, restoring divide steps and the registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_mb          <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_iter        <= '0;
            r_result      <= '0;
            r_exception   <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_sign;
                        r_exp  <= 10'({2'b00, w_a.exp}) - 10'({2'b00, w_b.exp})
                                  + 10'(FP_EXP_BIAS);
                        r_mb   <= {1'b1, w_b.mant};
                        r_rem  <= {2'b01, w_a.mant};
                        r_q    <= '0;
                        r_iter <= '0;
                        if (w_special) begin
                            r_result      <= w_spec_result;
                            r_exception   <= w_spec_exc;
                            r_div_by_zero <= w_spec_dbz;
                        end
                    end
                end
                ST_DIVIDE: begin
                    r_rem  <= w_rem_sub << 1;
                    r_q    <= {r_q[25:0], w_ge};
                    r_iter <= r_iter + 5'd1;
                end
                ST_ROUND: begin
                    r_result    <= w_rnd_result;
                    r_overflow  <= w_rnd_overflow;
                    r_underflow <= w_rnd_underflow;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_result      <= '0;
                        r_exception   <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_underflow   <= 1'b0;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_divider
// Description : Self-checking bench for fp32_divider; directed cases plus
//               random operands against an exact rational reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        Exception;
    logic        Overflow;
    logic        Underflow;
    logic        DivByZero;

    int n_total = 0;
    int n_bad   = 0;

    fp32_divider dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_operand(a_operand),
        .b_operand(b_operand),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .Exception(Exception),
        .Overflow (Overflow),
        .Underflow(Underflow),
        .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact reference: quotient value ma/mb * 2^(ea-eb), rounded from the true remainder.
    // Returns {Exception, Overflow, Underflow, DivByZero, result}.
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] ea, eb;
        logic       s;
        longint     ma, mb, num, n, r;
        int         e, sh;
        ea = a[30:23];
        eb = b[30:23];
        s  = a[31] ^ b[31];
        if (ea == 8'hFF || eb == 8'hFF) return {4'b1000, 32'd0};
        if (ea == 0 && eb == 0)         return {4'b1000, 32'd0};
        if (eb == 0)                    return {4'b0001, s, 8'hFF, 23'd0};
        if (ea == 0)                    return {4'b0000, s, 31'd0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        e  = int'(ea) - int'(eb) + 127;
        if (ma >= mb) sh = 23;
        else begin
            sh = 24;
            e  = e - 1;
        end
        num = ma << sh;
        n   = num / mb;
        r   = num % mb;
`ifdef FP_DIV_RNE_EN
        if ((2 * r > mb) || ((2 * r == mb) && (n % 2 == 1))) n = n + 1;
        if (n == (longint'(1) << 24)) begin
            n = longint'(1) << 23;
            e = e + 1;
        end
`endif
        if (e >= 255) return {4'b0100, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0010, s, 31'd0};
        return {4'b0000, s, 8'(e), 23'(n)};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'hFF;
        else               e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Called at #1 after a clock edge with the DUT idle
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          input bit inject, input string tag, output logic [31:0] got);
        logic [35:0] exp_v;
        int          lat;
        bit          special;
        exp_v   = ref_div(a, b);
        special = (a[30:23] == 0) || (b[30:23] == 0) || (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        check_eq({tag, "_rdy_pre"}, 32'(in_ready), 32'd1);
        a_operand = a;
        b_operand = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a_operand = $urandom;
        b_operand = $urandom;
        lat = 1;
        while (!out_valid && lat < 60) begin
            if (inject && lat == 5) begin
                in_valid = 1'b1;
                check_eq({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check_eq({tag, "_lat"}, 32'(lat), special ? 32'd1 : 32'd29);
        check_eq({tag, "_res"}, result, exp_v[31:0]);
        check_eq({tag, "_flags"}, {28'd0, Exception, Overflow, Underflow, DivByZero}, {28'd0, exp_v[35:32]});
        got = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_res"}, result, exp_v[31:0]);
            check_eq({tag, "_hold_vr"}, {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_post_vr"}, {30'd0, out_valid, in_ready}, 32'd1);
        check_eq({tag, "_post_out"}, {Exception, Overflow, Underflow, DivByZero, result[27:0]}, 32'd0);
        check_eq({tag, "_post_res_hi"}, {28'd0, result[31:28]}, 32'd0);
    endtask

    task automatic reset_abort();
        bit seen;
        logic [31:0] got;
        a_operand = 32'h40C00000;
        b_operand = 32'h40000000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_rdy", 32'(in_ready), 32'd1);
        check_eq("abort_res", result, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check_eq("abort_no_valid", 32'(seen), 32'd0);
        run_op(32'h40C00000, 32'h40000000, 0, 1'b0, "after_abort", got);
        check_eq("after_abort_val", got, 32'h40400000);
    endtask

    initial begin
        logic [31:0] got;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_operand = '0;
        b_operand = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_vr", {30'd0, out_valid, in_ready}, 32'd1);
        check_eq("rst_res", result, 32'd0);
        check_eq("rst_flags", {28'd0, Exception, Overflow, Underflow, DivByZero}, 32'd0);

        run_op(32'h40C00000, 32'h40000000, 0, 1'b0, "six_div_two", got);
        check_eq("six_div_two_val", got, 32'h40400000);
        run_op(32'h3F800000, 32'h40400000, 0, 1'b0, "third", got);
`ifdef FP_DIV_RNE_EN
        check_eq("third_val", got, 32'h3EAAAAAB);
`else
        check_eq("third_val", got, 32'h3EAAAAAA);
`endif
        run_op(32'h3F800000, 32'h00000000, 0, 1'b0, "pos_dbz", got);
        check_eq("pos_dbz_val", got, 32'h7F800000);
        run_op(32'hBF800000, 32'h00000000, 0, 1'b0, "neg_dbz", got);
        check_eq("neg_dbz_val", got, 32'hFF800000);
        run_op(32'h00000000, 32'h00000000, 0, 1'b0, "zero_zero", got);
        run_op(32'h00000000, 32'hC0000000, 0, 1'b0, "zero_x", got);
        check_eq("zero_x_val", got, 32'h80000000);
        run_op(32'h7F800000, 32'h3F800000, 0, 1'b0, "inf_x", got);
        run_op(32'h7F000000, 32'h3E800000, 0, 1'b0, "ovf", got);
        check_eq("ovf_val", got, 32'h7F800000);
        run_op(32'h00800000, 32'h40000000, 0, 1'b0, "unf", got);
        check_eq("unf_val", got, 32'h00000000);
        run_op(32'h40C00000, 32'h40000000, 5, 1'b1, "backpressure", got);
        check_eq("backpressure_val", got, 32'h40400000);

        reset_abort();

        for (int i = 0; i < 40; i++) begin
            run_op(rand_fp(), rand_fp(), (i % 7 == 0) ? 2 : 0, (i % 5 == 0), "rnd", got);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
